// File: rtl/alu_pkg.sv
// ALU_Control encodings shared by the ALU decoder and the multi-cycle
// multiply/divide sequencer, plus the sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_CTRL_AND  = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR   = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD  = 4'b0010;
  localparam logic [3:0] ALU_CTRL_XOR  = 4'b0100;
  localparam logic [3:0] ALU_CTRL_MULT = 4'b0101;
  localparam logic [3:0] ALU_CTRL_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT  = 4'b0111;
  localparam logic [3:0] ALU_CTRL_SLL  = 4'b1000;
  localparam logic [3:0] ALU_CTRL_SRL  = 4'b1001;
  localparam logic [3:0] ALU_CTRL_SRA  = 4'b1010;
  localparam logic [3:0] ALU_CTRL_DIV  = 4'b1011;
  localparam logic [3:0] ALU_CTRL_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // True for the codes that need the multi-cycle unit.
  function automatic logic is_md_op(input logic [3:0] code);
    return (code == ALU_CTRL_MULT) || (code == ALU_CTRL_DIV);
  endfunction

endpackage

// File: rtl/mult_div_sequencer_if.sv
// Request/result bundle between the main control path and the
// multiply/divide sequencer.
interface mult_div_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alu_control, operand_a, operand_b, flush, hi_wr, lo_wr, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, alu_control, operand_a, operand_b, flush, hi_wr, lo_wr, wr_data,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/mult_div_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on the
// 2*WIDTH accumulator; purely combinational.
module mult_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   bmag,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shl;
  logic [WIDTH:0]     diff;

  always_comb begin
    // Multiply: accumulator upper half collects the product, lower half holds
    // the remaining multiplier bits; the carry bit shifts back in.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bmag} : '0);
    // Divide: remainder in upper half never exceeds |b|-1 < 2^(WIDTH-1),
    // so the left shift cannot lose a bit.
    shl      = {acc[2*WIDTH-2:0], 1'b0};
    diff     = {1'b0, shl[2*WIDTH-1:WIDTH]} - {1'b0, bmag};
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
      end else begin
        acc_next = shl;
      end
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle signed multiply / divide controller owning HI/LO, with
// busy for pipeline stall, a done pulse and a sticky divide-by-zero flag.
module mult_div_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic                 clk,
  input logic                 reset,
  mult_div_sequencer_if.slave bus
);

  localparam int ACC_W = 2 * WIDTH;

  if (WIDTH < 2 || (2 ** CNT_W) <= WIDTH) begin : g_param_check
    $error("mult_div_sequencer: WIDTH must be >= 2 and 2**CNT_W > WIDTH");
  end

  md_state_t               state;
  md_state_t               state_next;
  logic [CNT_W-1:0]        cnt;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_next;
  logic [WIDTH-1:0]        bmag;
  logic                    res_sign;
  logic                    dvd_sign;
  logic                    is_div;
  logic                    b_zero;
  logic [WIDTH-1:0]        hi_r;
  logic [WIDTH-1:0]        lo_r;
  logic                    done_r;
  logic                    div_zero_r;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    accept;
  logic                    div_req;
  logic                    b_is_zero;
  logic                    last_iter;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic s);
    return s ? WIDTH'(-v) : v;
  endfunction

  function automatic logic [ACC_W-1:0] neg_acc(input logic [ACC_W-1:0] v, input logic s);
    return s ? ACC_W'(-v) : v;
  endfunction

  assign a_s       = bus.operand_a;
  assign b_s       = bus.operand_b;
  assign div_req   = (bus.alu_control == ALU_CTRL_DIV);
  assign b_is_zero = (b_s == '0);
  assign accept    = (state == IDLE) && bus.start && is_md_op(bus.alu_control);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  mult_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc),
    .bmag    (bmag),
    .is_div  (is_div),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (div_req && b_is_zero) ? FIX : CALC;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      acc        <= '0;
      bmag       <= '0;
      res_sign   <= 1'b0;
      dvd_sign   <= 1'b0;
      is_div     <= 1'b0;
      b_zero     <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_wr) hi_r <= bus.wr_data;
          if (bus.lo_wr) lo_r <= bus.wr_data;
          // Both multiply and divide start from {0, |a|} with |b| alongside.
          if (accept) begin
            acc      <= {{WIDTH{1'b0}}, mag(a_s)};
            bmag     <= mag(b_s);
            res_sign <= a_s[WIDTH-1] ^ b_s[WIDTH-1];
            dvd_sign <= a_s[WIDTH-1];
            is_div   <= div_req;
            b_zero   <= div_req && b_is_zero;
            cnt      <= '0;
            if (div_req && !b_is_zero) div_zero_r <= 1'b0;
          end
        end
        CALC: begin
          if (!bus.flush) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          // Sign fix-up: quotient/product take the XOR sign, remainder
          // follows the dividend.
          if (!bus.flush) begin
            done_r <= 1'b1;
            if (b_zero) begin
              div_zero_r <= 1'b1;
            end else if (is_div) begin
              lo_r <= neg_w(acc[WIDTH-1:0], res_sign);
              hi_r <= neg_w(acc[ACC_W-1:WIDTH], dvd_sign);
            end else begin
              {hi_r, lo_r} <= neg_acc(acc, res_sign);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed plus randomized checks of the multiply/divide sequencer against
// a plain signed-arithmetic reference model.
module tb_mult_div_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_hi = '0;
  logic [WIDTH-1:0] exp_lo = '0;
  logic             exp_dz = 1'b0;

  mult_div_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mult_div_sequencer #(
    .WIDTH(WIDTH),
    .CNT_W(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: 64-bit signed product, truncating quotient, remainder with dividend sign.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] code);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (code == ALU_CTRL_MULT) begin
      p = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (sb == 0) begin
      exp_dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
      exp_dz = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] code);
    int cyc, busy_cnt, exp_lat;
    bit seen_done, busy_at_done;
    bus.operand_a   = a;
    bus.operand_b   = b;
    bus.alu_control = code;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    model(a, b, code);
    exp_lat      = (code == ALU_CTRL_DIV && b == 0) ? 2 : LAT;
    cyc          = 1;
    busy_cnt     = 0;
    seen_done    = 1'b0;
    busy_at_done = 1'b1;
    while (cyc <= 100) begin
      if (bus.done === 1'b1) begin
        seen_done    = 1'b1;
        busy_at_done = bus.busy;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
    check({tag, " done_seen"}, seen_done, 1);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
    check({tag, " busy_at_done"}, busy_at_done, 0);
    check({tag, " hi"}, bus.hi, exp_hi);
    check({tag, " lo"}, bus.lo, exp_lo);
    check({tag, " div_zero"}, bus.div_zero, exp_dz);
    tick();
    check({tag, " done_width"}, bus.done, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rc;
    int          any_done;

    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.alu_control = '0;
    bus.operand_a   = '0;
    bus.operand_b   = '0;
    bus.flush       = 1'b0;
    bus.hi_wr       = 1'b0;
    bus.lo_wr       = 1'b0;
    bus.wr_data     = '0;
    #2;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset div_zero", bus.div_zero, 0);
    check("reset hi", bus.hi, 0);
    check("reset lo", bus.lo, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    run_op("mult_7x-3", 32'h0000_0007, 32'hFFFF_FFFD, ALU_CTRL_MULT);
    run_op("div_-7/2", 32'hFFFF_FFF9, 32'h0000_0002, ALU_CTRL_DIV);

    bus.hi_wr   = 1'b1;
    bus.wr_data = 32'h0000_1234;
    tick();
    bus.hi_wr   = 1'b0;
    bus.lo_wr   = 1'b1;
    bus.wr_data = 32'h0000_5678;
    tick();
    bus.lo_wr = 1'b0;
    exp_hi = 32'h0000_1234;
    exp_lo = 32'h0000_5678;
    check("mthi", bus.hi, exp_hi);
    check("mtlo", bus.lo, exp_lo);

    run_op("div_5/0", 32'd5, 32'd0, ALU_CTRL_DIV);
    run_op("div_9/3", 32'd9, 32'd3, ALU_CTRL_DIV);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, ALU_CTRL_DIV);
    run_op("mult_min", 32'h8000_0000, 32'h8000_0000, ALU_CTRL_MULT);

    for (int i = 0; i < 24; i++) begin
      rc = ($urandom_range(0, 1) == 0) ? ALU_CTRL_MULT : ALU_CTRL_DIV;
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3:       begin rb = $urandom; ra = 32'h8000_0000; end
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ra, rb, rc);
    end

    run_op("pre_flush", 32'd1000, 32'hFFFF_FFF0, ALU_CTRL_MULT);
    bus.operand_a   = 32'd11;
    bus.operand_b   = 32'd13;
    bus.alu_control = ALU_CTRL_MULT;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    any_done  = 0;
    for (int c = 1; c < 10; c++) begin
      if (bus.done === 1'b1) any_done++;
      tick();
    end
    bus.operand_a   = 32'd99;
    bus.operand_b   = 32'd77;
    bus.start       = 1'b1;
    bus.hi_wr       = 1'b1;
    bus.wr_data     = 32'hDEAD_BEEF;
    tick();
    bus.start = 1'b0;
    bus.hi_wr = 1'b0;
    for (int c = 11; c < 15; c++) begin
      if (bus.done === 1'b1) any_done++;
      tick();
    end
    check("flush busy_before", bus.busy, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush busy_after", bus.busy, 0);
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1) any_done++;
      tick();
    end
    check("flush no_done", any_done, 0);
    check("flush hi_kept", bus.hi, exp_hi);
    check("flush lo_kept", bus.lo, exp_lo);
    run_op("post_flush", 32'd12345, 32'hFFFF_FD5A, ALU_CTRL_MULT);

    bus.operand_a   = 32'd1000;
    bus.operand_b   = 32'd7;
    bus.alu_control = ALU_CTRL_DIV;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    check("pre_reset busy", bus.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset busy", bus.busy, 0);
    check("async_reset done", bus.done, 0);
    check("async_reset hi", bus.hi, 0);
    check("async_reset lo", bus.lo, 0);
    check("async_reset div_zero", bus.div_zero, 0);
    tick();
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;
    bus.operand_a   = 32'd4;
    bus.operand_b   = 32'd2;
    bus.alu_control = ALU_CTRL_ADD;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    check("invalid_code busy", bus.busy, 0);
    tick();
    check("invalid_code busy_later", bus.busy, 0);
    check("invalid_code done", bus.done, 0);

    run_op("after_reset", 32'hFFFF_FF9C, 32'd7, ALU_CTRL_DIV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
